gsu_icache_ctrl: RTL

- Parametrised instruction-cache controller for the GSU core.
- Generalises the fixed 512-byte cache, 32-bit `cache_flags` and CBR handling into a block with configurable line size and line count, and adds behaviour the core does not yet have:
  - line fill from Game Pak ROM/RAM through a req/ack memory port;
  - uncached bypass for fetches outside the cache window;
  - SNES-side cache preload through the $3100 window.
- Sits between the GSU fetch stage (PC/PBR) and the ROM/RAM arbiter.

---
 rtl/gsu_icache_ctrl_if.sv | 27 ++
 rtl/gsu_icache_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gsu_icache_ctrl_if.sv
// Fetch-side and memory-side handshake bundle for the GSU instruction cache.
// The cache controller uses the slave view; the fetch stage/arbiter side uses master.
interface gsu_icache_ctrl_if;
  logic        fetch_req;
  logic [7:0]  fetch_bank;
  logic [15:0] fetch_addr;
  logic [7:0]  fetch_data;
  logic        fetch_valid;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (
    output fetch_req, fetch_bank, fetch_addr,
    input  fetch_data, fetch_valid,
    input  mem_req, mem_addr,
    output mem_ack, mem_data
  );

  modport slave (
    input  fetch_req, fetch_bank, fetch_addr,
    output fetch_data, fetch_valid,
    output mem_req, mem_addr,
    input  mem_ack, mem_data
  );
endinterface

// File: rtl/gsu_icache_ctrl.sv
// GSU instruction-cache controller: CBR-relative window, line fill over a req/ack
// memory port, uncached bypass outside the window and SNES-side preload writes.
module gsu_icache_ctrl #(
  parameter  int LINE_BYTES  = 16,
  parameter  int NUM_LINES   = 32,
  localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES,
  localparam int OFF_W       = $clog2(CACHE_BYTES)
) (
  input  logic                 clkin,
  input  logic                 RESET,
  gsu_icache_ctrl_if.slave     bus,
  input  logic                 cbr_load,
  input  logic [15:0]          cbr_in,
  input  logic                 flush,
  input  logic                 snes_we,
  input  logic [OFF_W-1:0]     snes_waddr,
  input  logic [7:0]           snes_wdata,
  output logic [15:0]          cbr,
  output logic [NUM_LINES-1:0] line_valid,
  output logic                 busy
);
  localparam int LINE_W = $clog2(LINE_BYTES);
  localparam int IDX_W  = OFF_W - LINE_W;
  localparam logic [LINE_W-1:0] LAST_BEAT = LINE_W'(LINE_BYTES - 1);
  localparam logic [15:0] LINE_MASK = ~16'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HIT, BYPASS, FILL, RESP} state_t;

  state_t               state_reg, state_next;
  logic [15:0]          cbr_reg, cbr_next;
  logic [NUM_LINES-1:0] valid_reg, valid_next;
  logic [LINE_W-1:0]    beat_reg, beat_next;
  logic [IDX_W-1:0]     line_reg, line_next;
  logic [15:0]          base_reg, base_next;
  logic [15:0]          addr_reg, addr_next;
  logic [7:0]           bank_reg, bank_next;
  logic [7:0]           resp_reg, resp_next;
  logic                 stale_reg, stale_next;
  logic                 fill_done;

  logic [7:0]           ram [CACHE_BYTES];
  logic [7:0]           ram_rd_reg;

  // Offset is taken modulo 2^16, so addresses below CBR land far outside the window.
  logic [15:0]      win_off;
  logic             in_window;
  logic [IDX_W-1:0] req_line;
  logic [15:0]      fill_addr;

  assign win_off   = bus.fetch_addr - cbr_reg;
  assign in_window = {1'b0, win_off} < 17'(CACHE_BYTES);
  assign req_line  = win_off[OFF_W-1:LINE_W];
  assign fill_addr = base_reg + 16'(beat_reg);

  // SNES writes take the single write port; a colliding fill byte is dropped.
  logic             fill_beat;
  logic             ram_we;
  logic [OFF_W-1:0] ram_waddr;
  logic [7:0]       ram_wdata;

  assign fill_beat = (state_reg == FILL) && bus.mem_ack;
  assign ram_we    = snes_we || fill_beat;
  assign ram_waddr = snes_we ? snes_waddr : {line_reg, beat_reg};
  assign ram_wdata = snes_we ? snes_wdata : bus.mem_data;

  always_ff @(posedge clkin) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rd_reg <= ram[win_off[OFF_W-1:0]];
  end

  always_comb begin
    state_next = state_reg;
    cbr_next   = cbr_reg;
    beat_next  = beat_reg;
    line_next  = line_reg;
    base_next  = base_reg;
    addr_next  = addr_reg;
    bank_next  = bank_reg;
    resp_next  = resp_reg;
    stale_next = stale_reg;
    fill_done  = 1'b0;

    if (cbr_load) cbr_next = cbr_in & LINE_MASK;

    case (state_reg)
      IDLE: begin
        if (bus.fetch_req) begin
          addr_next = bus.fetch_addr;
          bank_next = bus.fetch_bank;
          if (in_window && valid_reg[req_line]) begin
            state_next = HIT;
          end else if (in_window) begin
            state_next = FILL;
            beat_next  = '0;
            line_next  = req_line;
            base_next  = bus.fetch_addr & LINE_MASK;
            stale_next = 1'b0;
          end else begin
            state_next = BYPASS;
          end
        end
      end
      HIT: state_next = IDLE;
      BYPASS: begin
        if (bus.mem_ack) begin
          resp_next  = bus.mem_data;
          state_next = RESP;
        end
      end
      FILL: begin
        // Any disturbance of this line's contents or of the window keeps it invalid.
        if (cbr_load || flush ||
            (snes_we && ((snes_waddr[OFF_W-1:LINE_W] == line_reg) || bus.mem_ack)))
          stale_next = 1'b1;
        if (bus.mem_ack) begin
          if (fill_addr == addr_reg) resp_next = bus.mem_data;
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            state_next = RESP;
            fill_done  = 1'b1;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic clr_all;
  logic snes_last;
  assign clr_all   = cbr_load || flush;
  assign snes_last = snes_we && (snes_waddr[LINE_W-1:0] == LAST_BEAT);

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
    logic set_fill;
    logic set_snes;
    assign set_fill = fill_done && !stale_next && (line_reg == IDX_W'(gi));
    assign set_snes = snes_last && (snes_waddr[OFF_W-1:LINE_W] == IDX_W'(gi));
    assign valid_next[gi] = clr_all ? 1'b0 : (valid_reg[gi] || set_fill || set_snes);
  end

  always_ff @(posedge clkin) begin
    if (RESET) begin
      state_reg <= IDLE;
      cbr_reg   <= '0;
      valid_reg <= '0;
      beat_reg  <= '0;
      line_reg  <= '0;
      base_reg  <= '0;
      addr_reg  <= '0;
      bank_reg  <= '0;
      resp_reg  <= '0;
      stale_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cbr_reg   <= cbr_next;
      valid_reg <= valid_next;
      beat_reg  <= beat_next;
      line_reg  <= line_next;
      base_reg  <= base_next;
      addr_reg  <= addr_next;
      bank_reg  <= bank_next;
      resp_reg  <= resp_next;
      stale_reg <= stale_next;
    end
  end

  always_comb begin
    bus.mem_req     = (state_reg == BYPASS) || (state_reg == FILL);
    bus.mem_addr    = 24'h0;
    bus.fetch_valid = (state_reg == HIT) || (state_reg == RESP);
    bus.fetch_data  = 8'h00;
    if (state_reg == BYPASS) bus.mem_addr = {bank_reg, addr_reg};
    if (state_reg == FILL)   bus.mem_addr = {bank_reg, fill_addr};
    if (state_reg == HIT)    bus.fetch_data = ram_rd_reg;
    if (state_reg == RESP)   bus.fetch_data = resp_reg;
  end

  assign cbr        = cbr_reg;
  assign line_valid = valid_reg;
  assign busy       = (state_reg != IDLE);
endmodule
